// File: rtl/mem_ls_responder.sv
// Memory-side responder: synchronizes the CPU request, issues a single memory
// access, waits for the matching valid (or a timeout) and returns ack/rdata/err.
module mem_ls_responder #(
  parameter int unsigned DATA_SIZE      = 32,
  parameter int unsigned ADDR_SIZE      = 11,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_SIZE-1:0] cpu_adrs,
  input  logic [DATA_SIZE-1:0] cpu_wdata,
  output logic                 cpu_ack,
  output logic [DATA_SIZE-1:0] cpu_rdata,
  output logic                 cpu_err,
  output logic                 mem_r_en,
  output logic [ADDR_SIZE-1:0] mem_r_adrs,
  input  logic                 mem_r_valid,
  input  logic [DATA_SIZE-1:0] mem_r_data,
  output logic                 mem_w_en,
  output logic [ADDR_SIZE-1:0] mem_w_adrs,
  output logic [DATA_SIZE-1:0] mem_w_data,
  input  logic                 mem_w_valid
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t                 state, state_d;
  logic [SYNC_STAGES-1:0] req_sync;
  logic                   req_s;
  logic                   cmd_we, cmd_we_d;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic                   valid;

  logic                   ack_d, err_d, r_en_d, w_en_d;
  logic [DATA_SIZE-1:0]   rdata_d, w_data_d;
  logic [ADDR_SIZE-1:0]   r_adrs_d, w_adrs_d;

  assign req_s = req_sync[SYNC_STAGES-1];
  // Only the valid belonging to the captured operation counts.
  assign valid = cmd_we ? mem_w_valid : mem_r_valid;

  // Request synchronizer; the only path from the CPU clock domain.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) req_sync <= '0;
    else         req_sync <= {req_sync[SYNC_STAGES-2:0], cpu_req};
  end

  // State, command, counter and all output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cmd_we     <= 1'b0;
      cnt        <= '0;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= '0;
      cpu_err    <= 1'b0;
      mem_r_en   <= 1'b0;
      mem_r_adrs <= '0;
      mem_w_en   <= 1'b0;
      mem_w_adrs <= '0;
      mem_w_data <= '0;
    end else begin
      state      <= state_d;
      cmd_we     <= cmd_we_d;
      cnt        <= cnt_d;
      cpu_ack    <= ack_d;
      cpu_rdata  <= rdata_d;
      cpu_err    <= err_d;
      mem_r_en   <= r_en_d;
      mem_r_adrs <= r_adrs_d;
      mem_w_en   <= w_en_d;
      mem_w_adrs <= w_adrs_d;
      mem_w_data <= w_data_d;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead.
  always_comb begin
    state_d  = state;
    cmd_we_d = cmd_we;
    cnt_d    = cnt;
    ack_d    = cpu_ack;
    rdata_d  = cpu_rdata;
    err_d    = cpu_err;
    r_en_d   = 1'b0;
    w_en_d   = 1'b0;
    r_adrs_d = mem_r_adrs;
    w_adrs_d = mem_w_adrs;
    w_data_d = mem_w_data;

    unique case (state)
      IDLE: begin
        if (req_s) begin
          // Buses are sampled here, once req is seen synchronized high.
          cmd_we_d = cpu_we;
          if (cpu_we) begin
            w_en_d   = 1'b1;
            w_adrs_d = cpu_adrs;
            w_data_d = cpu_wdata;
          end else begin
            r_en_d   = 1'b1;
            r_adrs_d = cpu_adrs;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (valid) begin
          if (!cmd_we) rdata_d = mem_r_data;
          err_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = ACK;
        end else if (cnt == CNT_LAST) begin
          if (!cmd_we) rdata_d = '0;
          err_d   = 1'b1;
          ack_d   = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ACK: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
